// File: rtl/reverb_comb_delay.sv
// reverb_comb_delay: feedback comb reverberator y[n] = x[n] + g*y[n-D] with saturation
// Clk/rst: clock and synchronous active-high reset (reset restarts history clear)
// In_Valid/In_Ready/In_Data: sample input handshake, x[n]
// Out_Valid/Out_Data: one-cycle output pulse carrying y[n], data held until next pulse
// Delay_Num/Fb_Gain/Bypass: per-sample controls latched on accept; Clear: zero history
// Busy: high whenever not idle
module reverb_comb_delay #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int GAIN_W = 8
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  output logic [DATA_W-1:0] Out_Data,
  input  logic [ADDR_W-1:0] Delay_Num,
  input  logic [GAIN_W-1:0] Fb_Gain,
  input  logic              Bypass,
  input  logic              Clear,
  output logic              Busy
);
  localparam int PW = DATA_W + GAIN_W + 1;
  localparam logic signed [PW-1:0] S_MAX = PW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [PW-1:0] S_MIN = ~S_MAX;
  typedef enum logic [2:0] {CLEAR, IDLE, READ, CALC, WRITE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] cnt, wp, d_r, de, addr;
  logic [GAIN_W-1:0] g_r;
  logic [DATA_W-1:0] x_r, rd, y_r, y, wdata;
  logic              byp_r, we, re;
  logic signed [PW-1:0] p, fb, s;
  always_comb begin
    de = d_r == '0 ? ADDR_W'(1) : d_r;
    addr = state == CLEAR ? cnt : state == READ ? wp - de : wp;
    we = !rst && (state == CLEAR || state == WRITE);
    re = !rst && state == READ;
    wdata = state == CLEAR ? '0 : y_r;
    p = PW'($signed(rd)) * PW'($signed({1'b0, g_r}));
    fb = p >>> GAIN_W;
    s = fb + PW'($signed(x_r));
    y = byp_r ? x_r : s > S_MAX ? S_MAX[DATA_W-1:0] : s < S_MIN ? S_MIN[DATA_W-1:0] : s[DATA_W-1:0];
    In_Ready = state == IDLE;
    Busy = state != IDLE;
  end
  always_ff @(posedge Clk) begin
    if (we) mem[addr] <= wdata;
    else if (re) rd <= mem[addr];
  end
  always_ff @(posedge Clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      wp <= '0;
      Out_Valid <= 1'b0;
      Out_Data <= '0;
    end else begin
      Out_Valid <= 1'b0;
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= IDLE;
            wp <= '0;
          end
        end
        IDLE: begin
          if (Clear) begin
            state <= CLEAR;
            cnt <= '0;
          end else if (In_Valid) begin
            x_r <= In_Data;
            d_r <= Delay_Num;
            g_r <= Fb_Gain;
            byp_r <= Bypass;
            state <= READ;
          end
        end
        READ: state <= CALC;
        CALC: begin
          y_r <= y;
          Out_Data <= y;
          Out_Valid <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          wp <= wp + 1'b1;
          state <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_reverb_comb_delay.sv
// tb_reverb_comb_delay: directed self-checking bench for reverb_comb_delay (ADDR_W=4)
module tb_reverb_comb_delay;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  delay_num = '0;
  logic [7:0]  fb_gain = '0;
  logic        bypass = 1'b0;
  logic        clear = 1'b0;
  logic        busy;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  reverb_comb_delay #(.DATA_W(16), .ADDR_W(4), .GAIN_W(8)) dut (
    .Clk(clk), .rst(rst), .In_Valid(in_valid), .In_Ready(in_ready), .In_Data(in_data),
    .Out_Valid(out_valid), .Out_Data(out_data), .Delay_Num(delay_num), .Fb_Gain(fb_gain),
    .Bypass(bypass), .Clear(clear), .Busy(busy)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_ready(input string tag, input int exp_cycles);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n, exp_cycles);
  endtask
  task automatic send(input string tag, input int x, input int d, input int g, input bit byp, input bit clr, input int expv);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    in_data = x[15:0];
    delay_num = d[3:0];
    fb_gain = g[7:0];
    bypass = byp;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = '0;
    if (clr) clear = 1'b1;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk(tag, int'($signed(out_data)), expv);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, int'(out_valid), 0);
  endtask
  task automatic do_clear(input string tag);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    wait_ready({tag, "_len"}, 16);
  endtask
  int imp [5] = '{1000, 500, 250, 125, 62};
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 1);
    rst = 1'b0;
    wait_ready("init_clear_len", 16);
    chk("idle_busy", int'(busy), 0);
    for (int i = 0; i < 17; i++)
      send($sformatf("imp_%0d", i), i == 0 ? 1000 : 0, 4, 128, 1'b0, 1'b0, i % 4 == 0 ? imp[i / 4] : 0);
    do_clear("clr_a");
    send("pos_sat0", 30000, 1, 255, 1'b0, 1'b0, 30000);
    send("pos_sat1", 30000, 1, 255, 1'b0, 1'b0, 32767);
    do_clear("clr_b");
    send("neg_sat0", -30000, 1, 255, 1'b0, 1'b0, -30000);
    send("neg_sat1", -30000, 1, 255, 1'b0, 1'b0, -32768);
    send("floor_fb", 0, 1, 255, 1'b0, 1'b0, -32640);
    do_clear("clr_c");
    send("byp0", 100, 2, 128, 1'b1, 1'b0, 100);
    send("byp1", 200, 2, 128, 1'b1, 1'b0, 200);
    send("byp2", 300, 2, 128, 1'b1, 1'b0, 300);
    send("byp_off", 0, 2, 128, 1'b0, 1'b0, 100);
    do_clear("clr_d");
    send("d0_a", 800, 0, 128, 1'b0, 1'b0, 800);
    send("d0_b", 0, 0, 128, 1'b0, 1'b0, 400);
    send("mid_clear", 0, 0, 128, 1'b0, 1'b1, 200);
    chk("mid_clear_idle", int'(in_ready), 1);
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("mid_clear_busy", int'(busy), 1);
    wait_ready("mid_clear_len", 16);
    send("after_clear", 0, 1, 255, 1'b0, 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
